// File: rtl/alu_operand_stage.sv
// Operand stage ahead of the ALU: B-operand select, EX/MEM > MEM/WB forwarding,
// and a single-entry valid/ready pipeline register holding the ALU inputs.

module alu_operand_fwd #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs_addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic            mem_we,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data
);
    // x0 is hardwired zero, so it never picks up a forwarded value.
    always_comb begin
        fwd_data = rf_data;
        if (rs_addr != 5'd0) begin
            if (mem_we && mem_rd == rs_addr)     fwd_data = mem_data;
            else if (wb_we && wb_rd == rs_addr)  fwd_data = wb_data;
        end
    end
endmodule

module alu_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [3:0]      in_alu_ctrl,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic            in_reg_write,
    input  logic            flush,
    input  logic            fwd_mem_we,
    input  logic            fwd_wb_we,
    input  logic [4:0]      fwd_mem_rd,
    input  logic [4:0]      fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic [XLEN-1:0] fwd_wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    output logic [4:0]      out_rd_addr,
    output logic            out_reg_write,
    output logic            out_illegal
);
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      ctrl;
        logic [4:0]      rd;
        logic            rw;
        logic            ill;
    } entry_t;

    logic [1:0][4:0]      rs_addr;
    logic [1:0][XLEN-1:0] rf_data;
    logic [1:0][XLEN-1:0] src_data;

    assign rs_addr = {in_rs2_addr, in_rs1_addr};
    assign rf_data = {in_rs2_data, in_rs1_data};

    for (genvar g = 0; g < 2; g++) begin : g_src
        alu_operand_fwd #(.XLEN(XLEN)) u_fwd (
            .rs_addr  (rs_addr[g]),
            .rf_data  (rf_data[g]),
            .mem_we   (fwd_mem_we),
            .mem_rd   (fwd_mem_rd),
            .mem_data (fwd_mem_data),
            .wb_we    (fwd_wb_we),
            .wb_rd    (fwd_wb_rd),
            .wb_data  (fwd_wb_data),
            .fwd_data (src_data[g])
        );
    end

    logic   valid_q, valid_d;
    entry_t entry_q, entry_d;
    logic   load;

    assign in_ready = !flush && (!valid_q || out_ready);
    assign load     = in_valid && in_ready;

    // Drain only drops valid; the data fields keep their last value.
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (flush) begin
            valid_d     = 1'b0;
            entry_d.rw  = 1'b0;
            entry_d.ill = 1'b0;
        end else if (load) begin
            valid_d      = 1'b1;
            entry_d.a    = src_data[0];
            entry_d.b    = in_use_imm ? in_imm : src_data[1];
            entry_d.ctrl = in_alu_ctrl;
            entry_d.rd   = in_rd_addr;
            entry_d.rw   = in_reg_write;
            entry_d.ill  = (in_alu_ctrl > 4'b1010);
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign out_valid     = valid_q;
    assign alu_a         = entry_q.a;
    assign alu_b         = entry_q.b;
    assign alu_ctrl      = entry_q.ctrl;
    assign out_rd_addr   = entry_q.rd;
    assign out_reg_write = valid_q && entry_q.rw;
    assign out_illegal   = entry_q.ill;
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered operand stage directly upstream of the ALU. It accepts one decoded instruction per handshake, selects the B operand (register or immediate), and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages. It holds the resolved A, B and 4-bit ALU control in a single-entry pipeline register that drives the ALU inputs. It supports back-pressure from the downstream stage and a pipeline flush.

## Interface
- XLEN, 32, datapath width of operands and forwarded data
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage can accept this cycle
- in_rs1_data, in_rs2_data  input  XLEN  register-file read data
- in_imm  input  XLEN  sign-extended immediate
- in_use_imm  input  1  1: B = in_imm; 0: B = forwarded rs2
- in_alu_ctrl  input  4  ALU operation code (0000 AND … 1010 MUL)
- in_rs1_addr, in_rs2_addr, in_rd_addr  input  5  register indices
- in_reg_write  input  1  instruction writes rd
- flush  input  1  discard held and incoming instruction
- fwd_mem_we, fwd_wb_we  input  1  EX/MEM, MEM/WB write enables
- fwd_mem_rd, fwd_wb_rd  input  5  EX/MEM, MEM/WB destination
- fwd_mem_data, fwd_wb_data  input  XLEN  EX/MEM, MEM/WB result
- out_valid  output  1  held entry valid
- out_ready  input  1  downstream consumes entry this cycle
- alu_a, alu_b  output  XLEN  registered ALU operands
- alu_ctrl  output  4  registered ALU control
- out_rd_addr  output  5  registered destination
- out_reg_write  output  1  registered write enable, already ANDed with out_valid
- out_illegal  output  1  held alu_ctrl is outside 0000–1010

## Operation
- Single-entry register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- in_ready = !flush && (!out_valid || out_ready). This is combinational and has no dependency on in_valid.
- Load happens when in_valid && in_ready. All output registers capture the resolved values, and out_valid becomes 1.
- Drain happens when out_valid && out_ready && !(in_valid && in_ready). out_valid becomes 0 and the data registers hold their last value.
- Stall happens when out_valid && !out_ready. All outputs hold bit-stable.
- Flush: out_valid is cleared on the next edge, and out_reg_write and out_illegal are cleared with it. Flush overrides load, and in_ready is 0 while flush is high.
- Forwarding for each source rsX, resolved at capture:
  - If fwd_mem_we && fwd_mem_rd==rsX && rsX!=0, use fwd_mem_data.
  - Else if fwd_wb_we && fwd_wb_rd==rsX && rsX!=0, use fwd_wb_data.
  - Else use in_rsX_data.
  - EX/MEM has priority over MEM/WB.
- Register x0 is never forwarded. rsX==0 always takes the register-file value.
- alu_b = in_use_imm ? in_imm : forwarded rs2. Forwarding logic is still evaluated when in_use_imm=1, but its result is unused.
- out_illegal = (in_alu_ctrl > 4'b1010), registered at load. The code is passed through unchanged; the ALU outputs 0 for such codes.
- The block has no arithmetic of its own. All operand paths are XLEN-wide with no width change.

## Timing
- Reset (rst_n=0, asynchronous) drives out_valid=0, alu_a=0, alu_b=0, alu_ctrl=4'b0000, out_rd_addr=0, out_reg_write=0 and out_illegal=0. in_ready is 1 after reset unless flush is high.
- Latency is 1 cycle. Inputs accepted at edge N appear on the outputs after edge N and remain until the consuming edge.
- Throughput is 1 instruction per cycle when out_ready is held at 1. Simultaneous drain and load in the same cycle is allowed.
- Forwarding inputs are sampled only on the load edge and are not tracked while stalled. Upstream hazard logic must not present an instruction whose producer retires during the stall.
- If rst_n is deasserted mid-stall, the entry is lost and outputs return to their reset values immediately.

## Test plan
- Reset, then load in_rs1_data=5, in_rs2_data=7, alu_ctrl=0010, rd=3 -> next cycle out_valid=1, alu_a=5, alu_b=7, alu_ctrl=0010, out_rd_addr=3.
- Forwarding priority: rs1=4 with fwd_mem (rd=4, data=0xAA, we=1) and fwd_wb (rd=4, data=0xBB, we=1) -> alu_a=0xAA. Drop fwd_mem_we -> alu_a=0xBB.
- x0 guard: rs2=0, fwd_mem_rd=0, fwd_mem_we=1, fwd_mem_data=0xFFFF, in_rs2_data=0 -> alu_b=0.
- Immediate select: in_use_imm=1, in_imm=0xFFFFFFF0, with a matching rs2 forward present -> alu_b=0xFFFFFFF0.
- Back-pressure: FULL with out_ready=0 for 3 cycles -> in_ready=0 and outputs bit-stable. Set out_ready=1 with in_valid=1 -> new entry loads on that same edge.
- Flush while FULL with in_valid=1 -> next cycle out_valid=0 and out_reg_write=0, and the incoming instruction is not accepted. Separately, in_alu_ctrl=1100 -> out_illegal=1.
